ssi_receiver: RTL

Receive end of the SSI link driven by the core's `SSI_STROBE`/`SSI_DATA` pair. It takes data-strobe encoded serial frames from an asynchronous transmitter and double-synchronises both lines into its own clock. It then recovers bits from line transitions, deframes fixed-width words with odd parity, and presents them on a valid/ready output. It sits on the bench/companion side of the link, or in any block that consumes the core's SSI stream.

---
 rtl/ssi_pkg.sv | 23 ++
 rtl/ssi_sync.sv | 34 +++
 rtl/ssi_receiver.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/ssi_pkg.sv
// ssi_pkg: shared definitions for the SSI link.
//   - ssi_rx_state_t : receiver deframer state (IDLE / RECV)
//   - SSI_WORD_W, SSI_IDLE_TIMEOUT : default link parameters
//   - ssi_odd_parity : parity bit that makes payload+parity XOR to 1;
//                      the transmitter uses it to generate the bit and the
//                      receiver uses it to check the bit.
package ssi_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } ssi_rx_state_t;

  localparam int SSI_WORD_W       = 8;
  localparam int SSI_IDLE_TIMEOUT = 64;

  // Payloads narrower than 32 bits are zero-extended by the caller; the
  // extra zeros do not change the XOR.
  function automatic logic ssi_odd_parity(input logic [31:0] payload);
    return ~(^payload);
  endfunction

endpackage

// File: rtl/ssi_sync.sv
// ssi_sync: two-flop synchroniser for one asynchronous line.
// Ports:
//   clk  in  sampling clock
//   rst  in  asynchronous active-high reset, clears both flops to 0
//   d    in  asynchronous input line
//   q    out synchronised level (two clk edges behind d)
module ssi_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/ssi_receiver.sv
// ssi_receiver: receive end of the data-strobe (DS) encoded SSI link.
// Both lines are synchronised into MASTER_CLK, bits are recovered from line
// transitions, WORD_W-bit MSB-first words with a trailing odd-parity bit are
// deframed and presented on a valid/ready output register.
//
// Handshake: rx_valid rises when a word is loaded and then holds, with
// rx_data/rx_parity_err stable, until the cycle in which rx_ready is also
// high; that cycle transfers the word. A word completing while the register
// is full and not being accepted is dropped and sets the sticky overflow.
//
// Ports:
//   MASTER_CLK    in  sole clock, rising edge
//   PORESET       in  asynchronous active-high reset
//   SSI_STROBE    in  strobe line (asynchronous)
//   SSI_DATA      in  data line (asynchronous)
//   rx_data       out received payload
//   rx_valid      out rx_data / rx_parity_err valid
//   rx_ready      in  consumer accepts when rx_valid && rx_ready
//   rx_parity_err out odd-parity check failed for the presented word
//   frame_err     out one-cycle pulse: partial frame aborted by timeout
//   overflow      out sticky: a completed word was dropped
//   overflow_clr  in  clears overflow (a simultaneous set wins)
module ssi_receiver
  import ssi_pkg::*;
#(
  parameter int WORD_W       = SSI_WORD_W,
  parameter int IDLE_TIMEOUT = SSI_IDLE_TIMEOUT
) (
  input  logic              MASTER_CLK,
  input  logic              PORESET,
  input  logic              SSI_STROBE,
  input  logic              SSI_DATA,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_parity_err,
  output logic              frame_err,
  output logic              overflow,
  input  logic              overflow_clr
);

  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam int TO_W  = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] WORD_CNT = CNT_W'(WORD_W);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(IDLE_TIMEOUT);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(IDLE_TIMEOUT - 1);

  // Synchronised lines
  logic data_s;
  logic strobe_s;

  ssi_sync u_sync_data (
    .clk (MASTER_CLK),
    .rst (PORESET),
    .d   (SSI_DATA),
    .q   (data_s)
  );

  ssi_sync u_sync_strobe (
    .clk (MASTER_CLK),
    .rst (PORESET),
    .d   (SSI_STROBE),
    .q   (strobe_s)
  );

  // State
  logic               data_smp_q,   data_smp_d;
  logic               strobe_smp_q, strobe_smp_d;
  logic [1:0]         warm_q,       warm_d;
  ssi_rx_state_t      state_q,      state_d;
  logic [CNT_W-1:0]   bit_cnt_q,    bit_cnt_d;
  logic [TO_W-1:0]    to_cnt_q,     to_cnt_d;
  logic [WORD_W-1:0]  shift_q,      shift_d;
  logic [WORD_W-1:0]  rx_data_q,    rx_data_d;
  logic               rx_valid_q,   rx_valid_d;
  logic               rx_perr_q,    rx_perr_d;
  logic               frame_err_q,  frame_err_d;
  logic               overflow_q,   overflow_d;

  logic line_event;
  logic word_done;
  logic word_perr;
  logic overflow_set;

  always_comb begin
    data_smp_d   = data_s;
    strobe_smp_d = strobe_s;
    warm_d       = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    to_cnt_d     = to_cnt_q;
    shift_d      = shift_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    rx_perr_d    = rx_perr_q;
    frame_err_d  = 1'b0;
    overflow_d   = overflow_q;
    word_done    = 1'b0;
    overflow_set = 1'b0;

    // DS coding: each bit toggles exactly one line, so data^strobe flips
    // once per bit. The first three cycles after reset are masked so that
    // the line levels at release (synchronisers start at 0) are not
    // mistaken for a transition.
    line_event = (warm_q == 2'd3) &&
                 ((data_s ^ strobe_s) != (data_smp_q ^ strobe_smp_q));

    // Parity of the completed word; the parity bit is the current data line.
    word_perr = (ssi_odd_parity(32'(shift_q)) != data_s);

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (line_event) begin
          state_d   = RECV;
          shift_d   = {shift_q[WORD_W-2:0], data_s};
          bit_cnt_d = CNT_W'(1);
          to_cnt_d  = '0;
        end else if (to_cnt_q != TO_MAX) begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      RECV: begin
        if (line_event) begin
          to_cnt_d = '0;
          if (bit_cnt_q == WORD_CNT) begin
            // Parity bit: the word is complete; the next event starts a
            // new frame without passing through IDLE.
            word_done = 1'b1;
            bit_cnt_d = '0;
          end else begin
            shift_d   = {shift_q[WORD_W-2:0], data_s};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else if (to_cnt_q == TO_LAST) begin
          // Counter reaches IDLE_TIMEOUT on this edge.
          to_cnt_d    = TO_MAX;
          state_d     = IDLE;
          frame_err_d = (bit_cnt_q != '0);
          bit_cnt_d   = '0;
          shift_d     = '0;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (word_done) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_perr_d  = word_perr;
        rx_valid_d = 1'b1;
      end else begin
        overflow_set = 1'b1;
      end
    end

    if (overflow_set) begin
      overflow_d = 1'b1;
    end else if (overflow_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge MASTER_CLK or posedge PORESET) begin
    if (PORESET) begin
      data_smp_q   <= 1'b0;
      strobe_smp_q <= 1'b0;
      warm_q       <= 2'd0;
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      to_cnt_q     <= '0;
      shift_q      <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_perr_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      data_smp_q   <= data_smp_d;
      strobe_smp_q <= strobe_smp_d;
      warm_q       <= warm_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      to_cnt_q     <= to_cnt_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_perr_q    <= rx_perr_d;
      frame_err_q  <= frame_err_d;
      overflow_q   <= overflow_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_perr_q;
  assign frame_err     = frame_err_q;
  assign overflow      = overflow_q;

endmodule
